// File: rtl/router_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// router_mem_arbiter_if
// Bundles the request/grant handshake and the buffer-memory port of the
// router memory arbiter.
//
//   master modport : requester side (router controllers / bench)
//     out rd_req, wr_req  per-requester level requests, held until granted
//     out req_addr        packed base addresses, requester i at [i*AW +: AW]
//     in  rd_gnt, wr_gnt  one-hot single-cycle grant pulses
//     in  xfer_done       one-hot single-cycle burst-complete pulse
//     in  mem_en, mem_we, mem_addr  buffer-memory port
//     in  owner_id, busy  current owner and activity flag
//   slave modport  : arbiter side, directions mirrored
// ----------------------------------------------------------------------------
interface router_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            rd_req;
  logic [NUM_REQ-1:0]            wr_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            rd_gnt;
  logic [NUM_REQ-1:0]            wr_gnt;
  logic [NUM_REQ-1:0]            xfer_done;
  logic                          mem_en;
  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [1:0]                    owner_id;
  logic                          busy;

  modport master (
    output rd_req, wr_req, req_addr,
    input  rd_gnt, wr_gnt, xfer_done, mem_en, mem_we, mem_addr, owner_id, busy
  );

  modport slave (
    input  rd_req, wr_req, req_addr,
    output rd_gnt, wr_gnt, xfer_done, mem_en, mem_we, mem_addr, owner_id, busy
  );
endinterface

// File: rtl/router_mem_arbiter.sv
// ----------------------------------------------------------------------------
// router_mem_arbiter
// Round-robin arbiter giving four router controllers exclusive access to a
// shared packet buffer. Each grant owns the memory for one fixed-length
// burst (one packet), then a release cycle pulses xfer_done to the owner.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : router_mem_arbiter_if.slave (requests in; grants, done, memory
//          port, owner_id and busy out -- all outputs registered)
//
// Build option
//   ARB_WRITE_PRIO_EN : when defined, any pending write request beats all
//   read requests; round-robin runs inside the write class, then the read
//   class, both sharing one last-owner pointer. When undefined a single
//   round-robin covers all requesters; a requester asking for both
//   directions gets its read first and its write at its next turn.
// ----------------------------------------------------------------------------
module router_mem_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  router_mem_arbiter_if.slave  bus
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [1:0]              last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]      wr_turn_q, wr_turn_d;
  logic [NUM_REQ-1:0]      rd_gnt_q, rd_gnt_d;
  logic [NUM_REQ-1:0]      wr_gnt_q, wr_gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    mem_en_q, mem_en_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]              owner_q, owner_d;
  logic                    busy_q, busy_d;

  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      cand;
  logic                    found;
  logic [1:0]              win;
  logic [1:0]              idx;
  logic                    win_wr;
  logic                    sel_valid;

  // Unpack the per-requester base addresses.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

`ifdef ARB_WRITE_PRIO_EN
  // Writes form their own, higher-priority class.
  logic wr_class;
  assign wr_class = |bus.wr_req;
  assign cand     = wr_class ? bus.wr_req : bus.rd_req;
  assign win_wr   = wr_class;
`else
  // One class; direction resolved per winner. wr_turn_q[i] remembers that
  // requester i just had a read served while its write was also waiting.
  assign cand   = bus.rd_req | bus.wr_req;
  assign win_wr = bus.wr_req[win] & (~bus.rd_req[win] | wr_turn_q[win]);
`endif

  // Round-robin search starting one past the last owner; the 2-bit index
  // wraps naturally.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_owner_q + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign sel_valid = (state_q == S_IDLE) && found;

  // A read grant to a requester that also holds a write owes it the write
  // turn; any write grant settles the debt.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_turn
      assign wr_turn_d[gi] = (sel_valid && (win == 2'(gi)))
                             ? (win_wr ? 1'b0 : bus.wr_req[gi])
                             : wr_turn_q[gi];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_owner_d = last_owner_q;
    rd_gnt_d     = '0;
    wr_gnt_d     = '0;
    done_d       = '0;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    owner_d      = owner_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (found) begin
          // Base and direction are captured here; mem_addr itself then
          // carries base+beat, so later req_addr changes cannot leak in.
          state_d    = S_BURST;
          beat_d     = '0;
          mem_en_d   = 1'b1;
          mem_we_d   = win_wr;
          mem_addr_d = addr_arr[win];
          owner_d    = win;
          busy_d     = 1'b1;
          if (win_wr) begin
            wr_gnt_d[win] = 1'b1;
          end else begin
            rd_gnt_d[win] = 1'b1;
          end
        end
      end

      S_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d         = S_RELEASE;
          mem_en_d        = 1'b0;
          mem_we_d        = 1'b0;
          done_d[owner_q] = 1'b1;
        end else begin
          beat_d     = beat_q + BEAT_W'(1);
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        end
      end

      S_RELEASE: begin
        // The pointer only moves on a completed burst, so an aborted
        // burst does not advance the rotation.
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        last_owner_d = owner_q;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      last_owner_q <= 2'(NUM_REQ - 1);  // next search starts at requester 0
      wr_turn_q    <= '0;
      rd_gnt_q     <= '0;
      wr_gnt_q     <= '0;
      done_q       <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      owner_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_owner_q <= last_owner_d;
      wr_turn_q    <= wr_turn_d;
      rd_gnt_q     <= rd_gnt_d;
      wr_gnt_q     <= wr_gnt_d;
      done_q       <= done_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rd_gnt    = rd_gnt_q;
  assign bus.wr_gnt    = wr_gnt_q;
  assign bus.xfer_done = done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.owner_id  = owner_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_router_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_router_mem_arbiter
// Bench for router_mem_arbiter: directed scenarios with literal expectations,
// then randomized request traffic. A cycle-level reference model derived
// from the arbitration rules runs alongside and is compared every cycle.
// Honours ARB_WRITE_PRIO_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_router_mem_arbiter;

  localparam int AW = 10;
  localparam int NR = 4;
  localparam int BL = 19;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  router_mem_arbiter_if #(.ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

  router_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .NUM_REQ   (NR),
    .BURST_LEN (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: m_k counts cycles since the grant (-1 = no transfer).
  // Cycles 0..BL-1 are memory beats, cycle BL is the done pulse.
  // --------------------------------------------------------------------------
  logic [3:0]    exp_rd_gnt, exp_wr_gnt, exp_done;
  logic          exp_en, exp_we, exp_busy;
  logic [AW-1:0] exp_addr;
  logic [1:0]    exp_owner;
  int            m_k, m_last, m_owner, m_win;
  bit            m_w;
  bit [3:0]      m_owe;
  logic [AW-1:0] m_base;

  initial begin
    exp_rd_gnt = '0; exp_wr_gnt = '0; exp_done = '0;
    exp_en = 0; exp_we = 0; exp_busy = 0; exp_addr = '0; exp_owner = '0;
    m_k = -1; m_last = NR - 1; m_owner = 0; m_owe = '0; m_base = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_rd_gnt = '0; exp_wr_gnt = '0; exp_done = '0;
        exp_en = 0; exp_we = 0; exp_busy = 0; exp_addr = '0; exp_owner = '0;
        m_k = -1; m_last = NR - 1; m_owe = '0;
      end else begin
        exp_rd_gnt = '0; exp_wr_gnt = '0; exp_done = '0;
        if (m_k < 0) begin
          m_win = -1;
          m_w   = 0;
`ifdef ARB_WRITE_PRIO_EN
          for (int j = 1; j <= NR; j++) begin
            int i;
            i = (m_last + j) % NR;
            if (m_win < 0 && bus.wr_req[i]) begin m_win = i; m_w = 1; end
          end
          for (int j = 1; j <= NR; j++) begin
            int i;
            i = (m_last + j) % NR;
            if (m_win < 0 && bus.rd_req[i]) begin m_win = i; m_w = 0; end
          end
`else
          for (int j = 1; j <= NR; j++) begin
            int i;
            i = (m_last + j) % NR;
            if (m_win < 0 && (bus.rd_req[i] || bus.wr_req[i])) begin
              m_win = i;
              m_w   = bus.wr_req[i] && (!bus.rd_req[i] || m_owe[i]);
            end
          end
`endif
          if (m_win >= 0) begin
            if (m_w) exp_wr_gnt[m_win] = 1'b1;
            else     exp_rd_gnt[m_win] = 1'b1;
            m_owe[m_win] = m_w ? 1'b0 : bus.wr_req[m_win];
            m_base    = bus.req_addr[m_win*AW +: AW];
            m_owner   = m_win;
            m_k       = 0;
            exp_en    = 1;
            exp_we    = m_w;
            exp_addr  = m_base;
            exp_owner = 2'(m_win);
            exp_busy  = 1;
          end
        end else if (m_k < BL - 1) begin
          m_k++;
          exp_addr = m_base + AW'(m_k);
        end else if (m_k == BL - 1) begin
          m_k = BL;
          exp_en = 0;
          exp_we = 0;
          exp_done[m_owner] = 1'b1;
        end else begin
          m_k = -1;
          exp_busy = 0;
          m_last = m_owner;
        end
      end
    end
  end

  // Compare process: DUT against model every cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_rd_gnt",    bus.rd_gnt,    exp_rd_gnt);
      chk("m_wr_gnt",    bus.wr_gnt,    exp_wr_gnt);
      chk("m_xfer_done", bus.xfer_done, exp_done);
      chk("m_mem_en",    bus.mem_en,    exp_en);
      chk("m_mem_we",    bus.mem_we,    exp_we);
      chk("m_mem_addr",  bus.mem_addr,  exp_addr);
      chk("m_busy",      bus.busy,      exp_busy);
      if (exp_busy) chk("m_owner_id", bus.owner_id, exp_owner);
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic reset_dut();
    bus.rd_req = '0;
    bus.wr_req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for the next grant pulse; cyc = negedges elapsed.
  task automatic wait_grant(input string name, output logic [3:0] rg,
                            output logic [3:0] wg, output int cyc);
    rg = '0; wg = '0; cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if ((bus.rd_gnt | bus.wr_gnt) != 0) begin
        rg = bus.rd_gnt;
        wg = bus.wr_gnt;
        break;
      end
    end
    if (rg == 0 && wg == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no grant within %0d cycles", name, cyc);
    end
    $display("[TB] %s: rd_gnt=%b wr_gnt=%b after %0d cycles addr=0x%0h", name, rg, wg, cyc, bus.mem_addr);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  logic [3:0] rg, wg;
  int cyc, cnt;

  initial begin
    rst = 1'b1;
    bus.rd_req   = '0;
    bus.wr_req   = '0;
    bus.req_addr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy",     bus.busy,      0);
    chk("rst_mem_en",   bus.mem_en,    0);
    chk("rst_mem_addr", bus.mem_addr,  0);
    chk("rst_owner",    bus.owner_id,  0);
    chk("rst_gnt",      {bus.rd_gnt, bus.wr_gnt, bus.xfer_done}, 0);
    rst = 1'b0;

    // Single read burst from requester 0
    set_addr(0, 10'h010);
    bus.rd_req = 4'b0001;
    wait_grant("t35", rg, wg, cyc);
    chk("t35_rd_gnt",  rg, 4'b0001);
    chk("t35_latency", cyc, 1);
    chk("t35_addr0",   bus.mem_addr, 10'h010);
    chk("t35_we",      bus.mem_we, 0);
    bus.rd_req = '0;
    repeat (BL - 1) @(negedge clk);
    chk("t35_addr_last", bus.mem_addr, 10'h022);
    chk("t35_en_last",   bus.mem_en, 1);
    @(negedge clk);
    chk("t35_done",    bus.xfer_done, 4'b0001);
    chk("t35_en_off",  bus.mem_en, 0);
    @(negedge clk);
    chk("t35_idle_busy", bus.busy, 0);

    // All four readers held: rotation 0,1,2,3,0 with 21-cycle spacing
    reset_dut();
    bus.rd_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant("t36", rg, wg, cyc);
      chk("t36_order", oh_idx(rg), g % 4);
      chk("t36_spacing", cyc, (g == 0) ? 1 : BL + 2);
    end
    bus.rd_req = '0;

    // Write burst wrapping past the top of memory
    reset_dut();
    set_addr(2, 10'h3F8);
    bus.wr_req = 4'b0100;
    wait_grant("t37", rg, wg, cyc);
    chk("t37_wr_gnt", wg, 4'b0100);
    chk("t37_we",     bus.mem_we, 1);
    chk("t37_addr0",  bus.mem_addr, 10'h3F8);
    bus.wr_req = '0;
    repeat (7) @(negedge clk);
    chk("t37_addr7", bus.mem_addr, 10'h3FF);
    @(negedge clk);
    chk("t37_addr8_wrap", bus.mem_addr, 10'h000);
    repeat (10) @(negedge clk);
    chk("t37_addr18", bus.mem_addr, 10'h00A);
    @(negedge clk);
    chk("t37_done", bus.xfer_done, 4'b0100);

    // Read from 0 against write from 1
    reset_dut();
    bus.rd_req = 4'b0001;
    bus.wr_req = 4'b0010;
    wait_grant("t38a", rg, wg, cyc);
`ifdef ARB_WRITE_PRIO_EN
    chk("t38_first_wr", wg, 4'b0010);
    chk("t38_first_rd", rg, 4'b0000);
    bus.wr_req = '0;
    wait_grant("t38b", rg, wg, cyc);
    chk("t38_second_rd", rg, 4'b0001);
    chk("t38_gap", cyc, BL + 2);
    bus.rd_req = '0;
`else
    chk("t38_first_rd", rg, 4'b0001);
    chk("t38_first_wr", wg, 4'b0000);
    bus.rd_req = '0;
    wait_grant("t38b", rg, wg, cyc);
    chk("t38_second_wr", wg, 4'b0010);
    chk("t38_gap", cyc, BL + 2);
    bus.wr_req = '0;
`endif

    // Reset in the middle of a burst
    reset_dut();
    set_addr(0, 10'h000);
    bus.rd_req = 4'b0001;
    wait_grant("t39a", rg, wg, cyc);
    bus.rd_req = '0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t39_busy",  bus.busy, 0);
    chk("t39_en",    bus.mem_en, 0);
    chk("t39_we",    bus.mem_we, 0);
    chk("t39_addr",  bus.mem_addr, 0);
    chk("t39_owner", bus.owner_id, 0);
    chk("t39_pulses", {bus.rd_gnt, bus.wr_gnt, bus.xfer_done}, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.xfer_done != 0) cnt++;
    end
    chk("t39_no_done", cnt, 0);
    set_addr(2, 10'h155);
    bus.rd_req = 4'b0100;
    wait_grant("t39b", rg, wg, cyc);
    chk("t39_regrant", rg, 4'b0100);
    chk("t39_latency", cyc, 1);
    chk("t39_base",    bus.mem_addr, 10'h155);
    bus.rd_req = '0;

    // Same requester asks for both directions
    reset_dut();
    set_addr(0, 10'h100);
    bus.rd_req = 4'b0001;
    bus.wr_req = 4'b0001;
    wait_grant("t40a", rg, wg, cyc);
`ifdef ARB_WRITE_PRIO_EN
    chk("t40_first_wr", wg, 4'b0001);
    bus.wr_req = '0;
    wait_grant("t40b", rg, wg, cyc);
    chk("t40_second_rd", rg, 4'b0001);
    bus.rd_req = '0;
`else
    chk("t40_first_rd", rg, 4'b0001);
    bus.rd_req = '0;
    wait_grant("t40b", rg, wg, cyc);
    chk("t40_second_wr", wg, 4'b0001);
    bus.wr_req = '0;
`endif
    chk("t40_gap", cyc, BL + 2);

    // Randomized traffic; requesters hold each request until its grant
    reset_dut();
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 1999) == 0);
      for (int i = 0; i < NR; i++) begin
        if (exp_rd_gnt[i]) bus.rd_req[i] = 1'b0;
        if (exp_wr_gnt[i]) bus.wr_req[i] = 1'b0;
        if (!bus.rd_req[i] && !bus.wr_req[i] && ($urandom_range(0, 3) == 0))
          set_addr(i, AW'($urandom));
        if (!bus.rd_req[i] && ($urandom_range(0, 9) == 0))  bus.rd_req[i] = 1'b1;
        if (!bus.wr_req[i] && ($urandom_range(0, 11) == 0)) bus.wr_req[i] = 1'b1;
      end
      if (exp_rd_gnt != 0 || exp_wr_gnt != 0)
        $display("[TB] rand grant rd=%b wr=%b owner=%0d base=0x%0h", exp_rd_gnt, exp_wr_gnt, exp_owner, exp_addr);
    end
    rst = 1'b0;
    bus.rd_req = '0;
    bus.wr_req = '0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
